uart_stream_emitter: RTL
========================

Name: uart_stream_emitter

Overview:
- Parametrised successor to the fixed byte emitter that sits between corescorecore's stream output and the board UART pin.
- Accepts a valid/ready byte stream with tlast into a FIFO and serialises it as 8N1/8N2-style UART frames.
- Adds a configurable baud divider, data width, stop bits and FIFO depth, plus optional end-of-line insertion after tlast.
- Drives uart_txd directly; an LED mirror output is provided for board tops.

Parameters:
- CLK_FREQ_HZ, 16000000, input clock frequency.
- BAUD_RATE, 57600, line rate; DIV = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE cycles per bit; DIV must be >= 2 (elaboration error otherwise).
- DATA_BITS, 8, payload bits per frame, range 5..8; i_tdata[DATA_BITS-1:0] used, upper bits ignored.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- FIFO_DEPTH, 16, entries; power of two, >= 2.
- EOL_EN, 1, when 1 append EOL_CHAR frame after every entry that carried tlast.
- EOL_CHAR, 8'h0A, character sent for end-of-line; low DATA_BITS bits used.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tdata  in  8  stream byte.
- i_tlast  in  1  last byte of message.
- i_tvalid  in  1  stream valid.
- o_tready  out  1  stream ready (= FIFO not full).
- o_uart_tx  out  1  serial output, idle high.
- o_led  out  1  equal to o_uart_tx.
- o_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
Reset (async assert, sync-released by the caller):
- o_uart_tx=1, o_tready=1, o_busy=0, o_level=0; FSM in IDLE; FIFO pointers 0; EOL pending flag 0.
- Reset mid-frame aborts the frame immediately; the line goes high asynchronously.

FIFO:
- Entry width DATA_BITS+1 (data, tlast). Push on i_tvalid && o_tready.
- o_tready is registered and equals !full.
- Simultaneous push and pop when full: the pop frees a slot, but o_tready stays 0 that cycle, so no push occurs. Simultaneous push and pop otherwise leave level unchanged.
- Pointers wrap at FIFO_DEPTH. o_level counts 0..FIFO_DEPTH.

FSM states: IDLE, START, DATA, STOP, with a bit counter and a baud counter 0..DIV-1.
- IDLE:
  - If EOL pending: load EOL_CHAR, clear pending, go to START.
  - Else if FIFO non-empty: pop head, load shift register, set pending = tlast & EOL_EN, go to START.
  - EOL always has priority over the next FIFO entry.
- START: line=0 for DIV cycles, then DATA with bit index 0.
- DATA: line = shift[0], LSB first. Each bit lasts DIV cycles. After DATA_BITS bits go to STOP.
- STOP: line=1 for STOP_BITS*DIV cycles, then IDLE.
- Timing:
  - IDLE->START pop occurs one cycle after FIFO becomes non-empty, so the start bit begins 2 cycles after the accepting handshake.
  - Frame length is (1+DATA_BITS+STOP_BITS)*DIV cycles.
  - Back-to-back frames add exactly 1 IDLE cycle between stop end and next start.
- o_busy = (state != IDLE) | (level != 0) | pending.
- o_uart_tx is registered; no combinational path from any input to o_uart_tx.

Test Plan:
- Reset with CLK_FREQ_HZ=1000000, BAUD_RATE=100000 (DIV=10): hold i_rst_n=0 -> o_uart_tx=1, o_tready=1, o_level=0, o_busy=0.
- Single byte 8'h55, tlast=0, EOL_EN=1 -> start bit low cycles 2..11 after handshake; bits 1,0,1,0,1,0,1,0 each 10 cycles; stop high 10 cycles; no EOL frame; o_busy falls after stop.
- Bytes "Hi" with tlast on 'i' -> frames 0x48, 0x69, 0x0A in order, each 100 cycles, 1-cycle gaps; with EOL_EN=0 only two frames.
- Fill: push 20 bytes back-to-back with FIFO_DEPTH=16 -> o_level reaches 16 at most, o_tready=0 while full, no byte lost or duplicated; the receiver model matches the sequence.
- STOP_BITS=2, DATA_BITS=7, byte 8'hFF -> 7 data ones, stop high 20 cycles, total frame 100 cycles.
- Assert i_rst_n=0 mid-DATA of byte 0x00 -> o_uart_tx=1 within the same cycle, o_level=0. After release, the next pushed byte transmits cleanly.

Source files
------------

// File: rtl/uart_stream_emitter.sv
// ---------------------------------------------------------------------------
// uart_stream_emitter
//
// Takes a valid/ready byte stream with tlast, buffers it in a small FIFO and
// sends each entry as a UART frame: one start bit, DATA_BITS data bits (LSB
// first), then STOP_BITS stop bits. When EOL_EN is set, an EOL_CHAR frame
// follows every entry that carried tlast.
//
// Ports:
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset
//   i_tdata    stream byte (only the low DATA_BITS bits are sent)
//   i_tlast    last byte of a message
//   i_tvalid   stream valid
//   o_tready   stream ready, registered, high while the FIFO is not full
//   o_uart_tx  registered serial output, idle high
//   o_led      copy of o_uart_tx for board LEDs
//   o_busy     high while a frame is on the line, data is queued or an EOL
//              frame is still owed
//   o_level    FIFO occupancy, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module uart_stream_emitter #(
   parameter int unsigned CLK_FREQ_HZ = 16000000,
   parameter int unsigned BAUD_RATE   = 57600,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter bit          EOL_EN      = 1'b1,
   parameter logic [7:0]  EOL_CHAR    = 8'h0A
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [7:0]                    i_tdata,
   input  logic                          i_tlast,
   input  logic                          i_tvalid,
   output logic                          o_tready,
   output logic                          o_uart_tx,
   output logic                          o_led,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int unsigned DIV = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = (DIV >= 2) ? $clog2(DIV) : 1;
   localparam int EW = DATA_BITS + 1;

   // Reject parameter sets that cannot produce a valid line signal.
   if (DIV < 2) begin : g_div_check
      $error("uart_stream_emitter: baud divider must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_data_check
      $error("uart_stream_emitter: DATA_BITS must be 5..8");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
      $error("uart_stream_emitter: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_stream_emitter: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state, state_next;
   logic [BW-1:0]         baud_cnt, baud_next;
   logic [2:0]            bit_cnt, bit_next;
   logic [DATA_BITS-1:0]  shift, shift_next;
   logic                  pending, pending_next;
   logic                  tx_next;

   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [LW-1:0]         level_next;
   logic [EW-1:0]         head;
   logic                  push, pop, baud_done;
   logic                  unused_tdata;

   assign unused_tdata = ^i_tdata;
   assign push         = i_tvalid && o_tready;
   assign head         = mem[rd_ptr];
   assign baud_done    = (baud_cnt == BW'(DIV - 1));
   assign o_led        = o_uart_tx;
   assign o_busy       = (state != IDLE) || (o_level != '0) || pending;

   // FIFO storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr] <= {i_tlast, i_tdata[DATA_BITS-1:0]};
      end
   end

   // Occupancy after this cycle's push/pop; ready is derived from it so the
   // registered o_tready always agrees with the registered o_level.
   always_comb begin
      level_next = o_level;
      if (push && !pop) begin
         level_next = o_level + LW'(1);
      end else if (!push && pop) begin
         level_next = o_level - LW'(1);
      end
   end

   // FIFO pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         o_level  <= '0;
         o_tready <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         o_level  <= level_next;
         o_tready <= (level_next != LW'(FIFO_DEPTH));
      end
   end

   // Transmitter state and line register. The line is driven from the next
   // state so each phase appears on the pin in the same cycle it is entered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         pending   <= 1'b0;
         o_uart_tx <= 1'b1;
      end else begin
         state     <= state_next;
         baud_cnt  <= baud_next;
         bit_cnt   <= bit_next;
         shift     <= shift_next;
         pending   <= pending_next;
         o_uart_tx <= tx_next;
      end
   end

   // Next-state logic. An owed EOL frame is sent before the next FIFO entry,
   // and bit_cnt is reused to count stop bits.
   always_comb begin
      state_next   = state;
      baud_next    = baud_cnt;
      bit_next     = bit_cnt;
      shift_next   = shift;
      pending_next = pending;
      pop          = 1'b0;
      tx_next      = 1'b1;

      case (state)
         IDLE: begin
            baud_next = '0;
            bit_next  = '0;
            if (pending) begin
               shift_next   = EOL_CHAR[DATA_BITS-1:0];
               pending_next = 1'b0;
               state_next   = START;
            end else if (o_level != '0) begin
               pop          = 1'b1;
               shift_next   = head[DATA_BITS-1:0];
               pending_next = head[DATA_BITS] & EOL_EN;
               state_next   = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_next  = '0;
               bit_next   = '0;
               state_next = DATA;
            end else begin
               baud_next = baud_cnt + BW'(1);
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_next  = '0;
               shift_next = shift >> 1;
               if (bit_cnt == 3'(DATA_BITS - 1)) begin
                  bit_next   = '0;
                  state_next = STOP;
               end else begin
                  bit_next = bit_cnt + 3'd1;
               end
            end else begin
               baud_next = baud_cnt + BW'(1);
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_next = '0;
               if (bit_cnt == 3'(STOP_BITS - 1)) begin
                  bit_next   = '0;
                  state_next = IDLE;
               end else begin
                  bit_next = bit_cnt + 3'd1;
               end
            end else begin
               baud_next = baud_cnt + BW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

endmodule
